fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch-side consumer of the branch decision: owns the PC, runs the imem req/ack fetch handshake,
//  and applies taken-branch redirects. On redirect it discards the in-flight fetch and squashes
//  younger instructions for FLUSH_CYCLES cycles. Sits between imem and the IF/ID register.
// PARAMETERS
//  PC_W          64   PC / branch-target width
//  INSTR_W       32   instruction width
//  RESET_PC      0    PC value after reset
//  FLUSH_CYCLES  2    cycles flush_out is held high per redirect (1..7)
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        asynchronous, active-high reset
//  br_valid     in   1        branch resolved this cycle
//  br_taken     in   1        resolved-taken (branch-compare select); ignored when !br_valid
//  br_target    in   PC_W     redirect address
//  imem_req     out  1        fetch request
//  imem_addr    out  PC_W     fetch address; stable while imem_req && !imem_ack
//  imem_ack     in   1        response valid, one cycle
//  imem_rdata   in   INSTR_W  instruction data, valid with imem_ack
//  if_valid     out  1        if_instr/if_pc valid to IF/ID
//  if_ready     in   1        IF/ID accepts (0 = stall)
//  if_pc        out  PC_W     PC of if_instr
//  if_instr     out  INSTR_W  fetched instruction
//  flush_out    out  1        squash IF/ID and ID/EX contents
//  misalign_err out  1        sticky: taken redirect target with br_target[1:0]!=0
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, imem_req=0, if_valid=0, flush_out=0, misalign_err=0, discard=0;
//   imem_req first rises the cycle after reset deasserts.
//  States: REQ  -> imem_req=1, imem_addr=pc; -> WAIT same edge.
//          WAIT -> hold req/addr; on imem_ack: if discard, clear it, -> REQ (data dropped);
//                  else latch if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+4, -> HOLD.
//          HOLD -> if_valid=1; when if_ready: if_valid=0, -> REQ.
//          FLUSH-> flush_out=1, counter FLUSH_CYCLES-1..0; at 0 -> REQ (or WAIT if discard pending).
//  Fetch latency: ack in cycle N -> if_valid in N+1; back-to-back min 3 cycles/instr.
//  Redirect = br_valid && br_taken && br_target[1:0]==0; overrides every state and stall:
//   pc=br_target, if_valid=0, flush counter loaded, -> FLUSH next edge.
//   In WAIT (ack not this cycle): imem_req stays high until ack (handshake never abandoned),
//   discard=1; that response is dropped, fetch of br_target issued afterwards.
//   Redirect and imem_ack same cycle: response dropped, no pending discard.
//   Redirect during FLUSH: pc reloaded, counter restarts.
//  br_valid && !br_taken: no state change (fall-through already fetched).
//  Misaligned taken target: redirect ignored, misalign_err=1 until reset.
//  pc+4 wraps modulo 2^PC_W; no carry-out.
//  Reset mid-handshake: req drops asynchronously; pending ack after reset ignored (state REQ).
// STRUCTURE
//  riscv_pkg: fetch state enum {REQ,WAIT,HOLD,FLUSH}, INSTR_BYTES=4, RESET_PC default.
//  Sub-module: flush_counter (load, decrement-to-zero, busy flag) feeding flush_out.
// TESTING
//  1 Reset, imem acks 1 cycle after req -> addrs 0,4,8; if_pc 0,4,8; if_valid 1 per instr.
//  2 if_ready=0 5 cycles in HOLD -> if_valid/if_instr held, no new imem_req, pc unchanged.
//  3 Taken br_target=0x100 in HOLD -> flush_out high 2 cycles, next imem_addr=0x100.
//  4 Taken br_target=0x200 in WAIT, ack 3 cycles later with 0xDEADBEEF -> never on if_instr;
//    next fetch addr 0x200.
//  5 br_valid=1,br_taken=0 -> no flush, sequence continues; br_target=0x102 taken ->
//    misalign_err=1 sticky, pc unchanged.
//  6 Assert reset in WAIT -> imem_req=0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit_pkg
// Purpose  : Shared types and constants for the fetch/redirect unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_redirect_unit_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    localparam int          C_INSTR_BYTES      = 4;
    localparam logic [63:0] C_DEFAULT_RESET_PC = 64'h0;
    localparam int          C_FLUSH_CNT_W      = 3;

    // A redirect target is usable only when it is instruction aligned
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit_if
// Purpose  : Branch-resolve, imem fetch handshake and IF/ID delivery signals.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_redirect_unit_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) ();
    // branch decision
    logic               br_valid;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    // instruction memory
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    // IF/ID delivery
    logic               if_valid;
    logic               if_ready;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;

    // fetch unit side
    modport master (
        input  br_valid, br_taken, br_target,
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    // surrounding pipeline / memory side
    modport slave (
        output br_valid, br_taken, br_target,
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_unit_flush_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit_flush_counter
// Purpose  : Loadable down-counter timing the squash window after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit_flush_counter #(
    parameter int CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    output logic                  o_busy,
    output logic                  o_done
);
    logic [CNT_W-1:0] r_count;
    logic             r_busy;

    // Load restarts the window; otherwise count down and release at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_count == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_unit
// Purpose  : Owns the PC, runs the imem req/ack fetch handshake, delivers
//            instructions to IF/ID and applies taken-branch redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int              PC_W         = 64,
    parameter int              INSTR_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(C_DEFAULT_RESET_PC),
    parameter int              FLUSH_CYCLES = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    fetch_redirect_unit_if.master  bus,
    output logic                   flush_out,
    output logic                   misalign_err
);
    localparam logic [C_FLUSH_CNT_W-1:0] C_FLUSH_LOAD = C_FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0]          C_PC_STEP    = PC_W'(C_INSTR_BYTES);

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_req;
    logic [PC_W-1:0]    r_addr;
    logic               r_if_valid;
    logic [PC_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;
    logic               r_discard;
    logic               r_misalign;

    logic               w_taken;
    logic               w_aligned;
    logic               w_redirect;
    logic               w_misalign;
    logic               w_flush_busy;
    logic               w_flush_done;

    assign w_taken    = bus.br_valid && bus.br_taken;
    assign w_aligned  = is_aligned(bus.br_target[1:0]);
    assign w_redirect = w_taken && w_aligned;
    assign w_misalign = w_taken && !w_aligned;

    fetch_redirect_unit_flush_counter #(
        .CNT_W (C_FLUSH_CNT_W)
    ) u_flush_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_redirect),
        .i_load_val (C_FLUSH_LOAD),
        .o_busy     (w_flush_busy),
        .o_done     (w_flush_done)
    );

    // Fetch sequencer; a valid redirect takes priority over every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_REQ;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_discard  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_misalign <= 1'b1;
            end

            if (w_redirect) begin
                r_pc       <= bus.br_target;
                r_if_valid <= 1'b0;
                r_state    <= ST_FLUSH;
                // an outstanding request is never abandoned: its response
                // is either dropped now or marked for dropping later
                if (r_req) begin
                    if (bus.imem_ack) begin
                        r_req     <= 1'b0;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    ST_REQ: begin
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (bus.imem_ack) begin
                            r_req <= 1'b0;
                            if (r_discard) begin
                                r_discard <= 1'b0;
                                r_state   <= ST_REQ;
                            end else begin
                                r_if_instr <= bus.imem_rdata;
                                r_if_pc    <= r_pc;
                                r_if_valid <= 1'b1;
                                r_pc       <= r_pc + C_PC_STEP;
                                r_state    <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (bus.if_ready) begin
                            r_if_valid <= 1'b0;
                            r_state    <= ST_REQ;
                        end
                    end
                    ST_FLUSH: begin
                        // a stale response may land while squashing
                        if (r_req && bus.imem_ack) begin
                            r_req     <= 1'b0;
                            r_discard <= 1'b0;
                        end
                        if (w_flush_done) begin
                            r_state <= (r_req && !bus.imem_ack) ? ST_WAIT : ST_REQ;
                        end
                    end
                    default: begin
                        r_state <= ST_REQ;
                    end
                endcase
            end
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_if_instr;
    assign flush_out     = w_flush_busy;
    assign misalign_err  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_unit
// Purpose  : Self-checking bench for fetch_redirect_unit with a
//            transaction-level reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_unit;
    localparam int          PC_W         = 64;
    localparam int          INSTR_W      = 32;
    localparam logic [63:0] RESET_PC     = 64'h0;
    localparam int          FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush_out;
    logic misalign_err;

    fetch_redirect_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_redirect_unit #(
        .PC_W         (PC_W),
        .INSTR_W      (INSTR_W),
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush_out    (flush_out),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls
    int lat    = 1;
    bit poison = 0;
    int mcnt   = 0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (poison && a == 64'h104) return 32'hDEADBEEF;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no event, required event within cycle bound (t=%0t)", name, $time);
    endtask

    // imem responder: ack lat cycles after the request is first seen
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !bus.imem_req || bus.imem_ack) begin
                bus.imem_ack = 1'b0;
                mcnt = 0;
            end else begin
                mcnt++;
                if (mcnt >= lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = memf(bus.imem_addr);
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } deliv_t;

    deliv_t      q[$];
    logic [63:0] issued[$];
    int          vstamp[$];
    logic [63:0] m_exp_addr = RESET_PC;
    logic [63:0] m_held     = '0;
    bit          m_out = 0, m_taint = 0, m_mis = 0, p_valid = 0, saw_bad = 0;
    int          m_flush = 0;
    int          n_acc = 0;
    int          cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("rst_imem_req", bus.imem_req, 0);
                check("rst_if_valid", bus.if_valid, 0);
                check("rst_flush_out", flush_out, 0);
                check("rst_misalign", misalign_err, 0);
                q.delete();
                m_exp_addr = RESET_PC;
                m_out = 0; m_taint = 0; m_mis = 0; m_flush = 0; p_valid = 0;
            end else begin
                bit redir;
                check("if_valid", bus.if_valid, q.size() != 0);
                if (bus.if_valid && q.size() != 0) begin
                    check("if_pc", bus.if_pc, q[0].pc);
                    check("if_instr", bus.if_instr, q[0].instr);
                end
                check("flush_out", flush_out, m_flush > 0);
                check("misalign_err", misalign_err, m_mis);
                check("req_during_valid", bus.imem_req && bus.if_valid, 0);
                if (m_out) begin
                    check("req_held", bus.imem_req, 1);
                    check("addr_held", bus.imem_addr, m_held);
                end else if (bus.imem_req) begin
                    check("issue_addr", bus.imem_addr, m_exp_addr);
                    check("issue_in_flush", flush_out, 0);
                    m_held = bus.imem_addr;
                    issued.push_back(bus.imem_addr);
                end
                if (bus.if_valid && bus.if_instr == 32'hDEADBEEF) saw_bad = 1;
                if (bus.if_valid && !p_valid) vstamp.push_back(cyc);
                p_valid = bus.if_valid;

                // advance the model by this cycle's inputs
                redir = bus.br_valid && bus.br_taken && (bus.br_target[1:0] == 2'b00);
                if (bus.br_valid && bus.br_taken && bus.br_target[1:0] != 2'b00) m_mis = 1;
                if (redir) begin
                    q.delete();
                end else if (bus.if_valid && bus.if_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    n_acc++;
                end
                if (bus.imem_req) begin
                    if (redir) m_taint = 1;
                    if (bus.imem_ack) begin
                        if (!m_taint) begin
                            q.push_back('{m_held, memf(m_held)});
                            m_exp_addr = m_held + 64'd4;
                        end
                        m_taint = 0;
                        m_out = 0;
                    end else begin
                        m_out = 1;
                    end
                end else begin
                    m_out = 0;
                end
                if (redir) begin
                    m_exp_addr = bus.br_target;
                    m_flush = FLUSH_CYCLES;
                end else if (m_flush > 0) begin
                    m_flush--;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!bus.if_valid && k < 60) begin step(); k++; end
        if (!bus.if_valid) timeout(name);
    endtask

    task automatic wait_acc(input string name, input int n);
        int k = 0;
        while (n_acc < n && k < 100) begin step(); k++; end
        if (n_acc < n) timeout(name);
    endtask

    task automatic wait_wait_state(input string name);
        int k = 0;
        while (!(bus.imem_req && !bus.imem_ack) && k < 60) begin step(); k++; end
        if (!(bus.imem_req && !bus.imem_ack)) timeout(name);
    endtask

    task automatic pulse_accept();
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
    endtask

    task automatic branch(input logic taken, input logic [63:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_taken  = taken;
        bus.br_target = tgt;
        step();
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] held;
        int          base;
        reset         = 1'b1;
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        bus.if_ready  = 1'b1;
        repeat (3) step();
        check("reset_req", bus.imem_req, 0);
        check("reset_valid", bus.if_valid, 0);
        reset = 1'b0;

        // 1: sequential fetch with single-cycle memory
        wait_acc("t1_three_instr", 3);
        bus.if_ready = 1'b0;
        check("t1_issue_count", issued.size() >= 3, 1);
        if (issued.size() >= 3) begin
            check("t1_addr0", issued[0], 64'h0);
            check("t1_addr1", issued[1], 64'h4);
            check("t1_addr2", issued[2], 64'h8);
        end
        if (vstamp.size() >= 2) check("t1_spacing", vstamp[1] - vstamp[0], 3);
        else timeout("t1_spacing");

        // 2: stall in HOLD for 5 cycles
        wait_valid("t2_valid");
        check("t2_pc", bus.if_pc, 64'hC);
        check("t2_instr", bus.if_instr, 32'h00000C13);
        held = bus.if_instr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", bus.if_valid, 1);
            check("t2_hold_instr", bus.if_instr, held);
            check("t2_no_req", bus.imem_req, 0);
        end
        pulse_accept();

        // 3: taken redirect while holding
        wait_valid("t3_valid");
        check("t3_pc_before", bus.if_pc, 64'h10);
        branch(1'b1, 64'h100);
        check("t3_flush_c1", flush_out, 1);
        check("t3_squash", bus.if_valid, 0);
        step();
        check("t3_flush_c2", flush_out, 1);
        step();
        check("t3_flush_end", flush_out, 0);
        wait_valid("t3_target_valid");
        check("t3_target_addr", issued[$], 64'h100);
        check("t3_target_pc", bus.if_pc, 64'h100);
        pulse_accept();

        // 4: redirect while waiting on a slow response that must be dropped
        lat = 4;
        poison = 1;
        wait_wait_state("t4_wait");
        check("t4_wait_addr", bus.imem_addr, 64'h104);
        branch(1'b1, 64'h200);
        check("t4_req_kept", bus.imem_req, 1);
        wait_valid("t4_target_valid");
        check("t4_target_addr", issued[$], 64'h200);
        check("t4_target_pc", bus.if_pc, 64'h200);
        check("t4_target_instr", bus.if_instr, 32'h00020013);
        check("t4_no_stale", saw_bad, 0);
        lat = 1;
        poison = 0;
        pulse_accept();

        // 5: not-taken branch and misaligned taken target
        branch(1'b0, 64'h300);
        check("t5_nt_flush1", flush_out, 0);
        step();
        check("t5_nt_flush2", flush_out, 0);
        wait_valid("t5_valid");
        check("t5_seq_pc", bus.if_pc, 64'h204);
        branch(1'b1, 64'h102);
        check("t5_misalign", misalign_err, 1);
        check("t5_not_squashed", bus.if_valid, 1);
        check("t5_no_flush", flush_out, 0);
        pulse_accept();
        wait_valid("t5_next_valid");
        check("t5_next_pc", bus.if_pc, 64'h208);
        repeat (3) step();
        check("t5_sticky", misalign_err, 1);
        pulse_accept();

        // 6: asynchronous reset in the middle of a handshake
        lat = 4;
        wait_wait_state("t6_wait");
        #1;
        reset = 1'b1;
        #1;
        check("t6_req_async_drop", bus.imem_req, 0);
        check("t6_misalign_clear", misalign_err, 0);
        lat = 1;
        bus.if_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("t6_req_low_release", bus.imem_req, 0);
        step();
        check("t6_req_rises", bus.imem_req, 1);
        check("t6_restart_addr", bus.imem_addr, RESET_PC);
        base = n_acc;
        wait_acc("t6_resume", base + 2);
        check("t6_resume_addr", issued[$], 64'h4);

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
